// File: rtl/adpll_launch_pkg.sv
// rtl/adpll_launch_pkg.sv - shared state type, counter width and timer sizing for the DCO word launcher
package adpll_launch_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} launch_state_t;

  localparam int LAUNCH_CNT_W = 16;

  // Narrowest down-counter that can hold the longest phase length minus one.
  function automatic int timer_w(input int setup, input int pulse, input int hold);
    int m;
    m = setup;
    if (pulse > m) m = pulse;
    if (hold > m) m = hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/launch_timer.sv
// rtl/launch_timer.sv - loadable down-counter that flags when a launch phase has run out
module launch_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dco_word_launcher.sv
// rtl/dco_word_launcher.sv - launches tuning words into the DCO capture bank with setup/pulse/hold spacing
// Optional LAUNCHER_SKIP_SAME_EN: a word equal to the current dco_d completes at once without a strobe.
module dco_word_launcher
  import adpll_launch_pkg::*;
#(
  parameter int W         = 12,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [W-1:0]            in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [W-1:0]            dco_d,
  output logic                    dco_ck,
  output logic                    busy,
  output logic                    done,
  output logic [LAUNCH_CNT_W-1:0] launch_cnt
);

  localparam int TW = timer_w(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD  = (HOLD_CYC > 0) ? TW'(HOLD_CYC - 1) : '0;

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 0) begin : g_bad_params
    $fatal(1, "dco_word_launcher: illegal SETUP_CYC/PULSE_CYC/HOLD_CYC");
  end

  launch_state_t state, state_next;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_zero;
  logic          capture;
  logic          ck_next;
  logic          done_next;
  logic          cnt_inc;

  launch_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = SETUP_LD;
    capture    = 1'b0;
    ck_next    = dco_ck;
    done_next  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
`ifdef LAUNCHER_SKIP_SAME_EN
          if (in_data == dco_d) begin
            done_next = 1'b1;
          end else begin
            state_next = SETUP;
            timer_load = 1'b1;
            timer_val  = SETUP_LD;
          end
`else
          state_next = SETUP;
          timer_load = 1'b1;
          timer_val  = SETUP_LD;
`endif
        end
      end
      SETUP: begin
        if (timer_zero) begin
          state_next = STROBE;
          ck_next    = 1'b1;
          cnt_inc    = 1'b1;
          timer_load = 1'b1;
          timer_val  = PULSE_LD;
        end
      end
      STROBE: begin
        if (timer_zero) begin
          ck_next = 1'b0;
          // With no hold requirement the word may be replaced right after the falling strobe.
          if (HOLD_CYC > 0) begin
            state_next = HOLD;
            timer_load = 1'b1;
            timer_val  = HOLD_LD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (timer_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dco_d      <= '0;
      dco_ck     <= 1'b0;
      done       <= 1'b0;
      launch_cnt <= '0;
    end else begin
      if (capture) begin
        dco_d <= in_data;
      end
      dco_ck <= ck_next;
      done   <= done_next;
      if (cnt_inc) begin
        launch_cnt <= launch_cnt + LAUNCH_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dco_word_launcher.sv
// tb/tb_dco_word_launcher.sv - directed checks of launch timing, back-to-back, reset abort, wrap and options
module tb_dco_word_launcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, dco_ck, busy, done;
  logic [11:0] dco_d;
  logic [15:0] launch_cnt;

  logic [11:0] h_in_data = '0;
  logic        h_in_valid = 1'b0;
  logic        h_in_ready, h_dco_ck, h_busy, h_done;
  logic [11:0] h_dco_d;
  logic [15:0] h_launch_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dco_word_launcher #(.W(12), .SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dco_d(dco_d), .dco_ck(dco_ck), .busy(busy), .done(done), .launch_cnt(launch_cnt)
  );

  dco_word_launcher #(.W(12), .SETUP_CYC(2), .PULSE_CYC(2), .HOLD_CYC(0)) dut_nohold (
    .clk(clk), .rst(rst), .in_data(h_in_data), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .dco_d(h_dco_d), .dco_ck(h_dco_ck), .busy(h_busy), .done(h_done), .launch_cnt(h_launch_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    h_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({in_ready, busy, dco_ck, done} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags got %b exp 1000", {in_ready, busy, dco_ck, done});
    end
    tests++;
    if (dco_d !== 12'h000 || launch_cnt !== 16'h0000) begin
      fails++;
      $display("FAIL reset_regs got d=%h cnt=%h exp d=000 cnt=0000", dco_d, launch_cnt);
    end
    tests++;
    if ({h_in_ready, h_busy, h_dco_ck, h_done} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_nohold got %b exp 1000", {h_in_ready, h_busy, h_dco_ck, h_done});
    end
  endtask

  // Observed tuple per cycle: {dco_ck, done, in_ready, dco_d}
  task automatic test_single();
    logic [14:0] exp;
    do_reset();
    @(negedge clk);
    in_data = 12'h2A5;
    in_valid = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      exp = {(c == 2 || c == 3), (c == 5), (c == 5), 12'h2A5};
      tests++;
      if ({dco_ck, done, in_ready, dco_d} !== exp) begin
        fails++;
        $display("FAIL single c=%0d got %h exp %h", c, {dco_ck, done, in_ready, dco_d}, exp);
      end
      if (c == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 12'hFFF;
      end
    end
    tests++;
    if (launch_cnt !== 16'd1) begin
      fails++;
      $display("FAIL single_cnt got %0d exp 1", launch_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] words [3];
    logic [14:0] exp;
    words[0] = 12'h001;
    words[1] = 12'h002;
    words[2] = 12'h003;
    do_reset();
    @(negedge clk);
    in_data = words[0];
    in_valid = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      exp = {((c % 6) == 2 || (c % 6) == 3), ((c % 6) == 5), ((c % 6) == 5), words[c / 6]};
      tests++;
      if ({dco_ck, done, in_ready, dco_d} !== exp) begin
        fails++;
        $display("FAIL b2b c=%0d got %h exp %h", c, {dco_ck, done, in_ready, dco_d}, exp);
      end
      if ((c % 6) == 5) begin
        @(negedge clk);
        if (c / 6 < 2) in_data = words[c / 6 + 1];
        else in_valid = 1'b0;
      end
    end
    tests++;
    if (launch_cnt !== 16'd3) begin
      fails++;
      $display("FAIL b2b_cnt got %0d exp 3", launch_cnt);
    end
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    @(negedge clk);
    in_data = 12'h155;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({dco_ck, busy} !== 2'b11) begin
      fails++;
      $display("FAIL abort_pre got ck/busy=%b exp 11", {dco_ck, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({dco_ck, done, in_ready, busy, dco_d} !== {4'b0010, 12'h000}) begin
      fails++;
      $display("FAIL abort got %h exp %h", {dco_ck, done, in_ready, busy, dco_d}, {4'b0010, 12'h000});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests++;
      if ({dco_ck, done, in_ready} !== 3'b001) begin
        fails++;
        $display("FAIL abort_after c=%0d got %b exp 001", c, {dco_ck, done, in_ready});
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    force dut.launch_cnt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.launch_cnt;
    tests++;
    if (launch_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_preload got %h exp ffff", launch_cnt);
    end
    in_data = 12'h3C3;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({done, launch_cnt} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL wrap got done=%b cnt=%h exp done=1 cnt=0000", done, launch_cnt);
    end
  endtask

  task automatic test_no_hold();
    logic [14:0] exp;
    do_reset();
    @(negedge clk);
    h_in_data = 12'h7FF;
    h_in_valid = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      exp = {(c == 2 || c == 3), (c == 4), (c == 4), 12'h7FF};
      tests++;
      if ({h_dco_ck, h_done, h_in_ready, h_dco_d} !== exp) begin
        fails++;
        $display("FAIL nohold c=%0d got %h exp %h", c, {h_dco_ck, h_done, h_in_ready, h_dco_d}, exp);
      end
      if (c == 0) begin
        @(negedge clk);
        h_in_valid = 1'b0;
      end
    end
    tests++;
    if (h_launch_cnt !== 16'd1) begin
      fails++;
      $display("FAIL nohold_cnt got %0d exp 1", h_launch_cnt);
    end
  endtask

  task automatic test_same_word();
    logic       skip;
    logic [3:0] exp;
`ifdef LAUNCHER_SKIP_SAME_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    do_reset();
    @(negedge clk);
    in_data = 12'h100;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({done, launch_cnt} !== {1'b1, 16'd1}) begin
      fails++;
      $display("FAIL same_first got done=%b cnt=%0d exp done=1 cnt=1", done, launch_cnt);
    end
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    exp = skip ? 4'b0110 : 4'b0001;
    tests++;
    if ({dco_ck, done, in_ready, busy} !== exp) begin
      fails++;
      $display("FAIL same_accept got %b exp %b", {dco_ck, done, in_ready, busy}, exp);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (dco_ck !== (!skip && (c == 2 || c == 3))) begin
        fails++;
        $display("FAIL same_ck c=%0d got %b exp %b", c, dco_ck, (!skip && (c == 2 || c == 3)));
      end
    end
    tests++;
    if (launch_cnt !== (skip ? 16'd1 : 16'd2)) begin
      fails++;
      $display("FAIL same_cnt got %0d exp %0d", launch_cnt, (skip ? 1 : 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid_strobe();
    test_wrap();
    test_no_hold();
    test_same_word();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
